// File: rtl/eff_sel_ctrl.sv
// Click-free effect-selection controller.
// Switches are synchronised and debounced. Every accepted change of the target select
// word runs one sequence: ramp the output gain to zero, swap the select word, discard
// stale samples at zero gain, then ramp the gain back to unity. Samples keep flowing.
module eff_sel_ctrl #(
  parameter int DATA_WIDTH      = 24,
  parameter int SEL_WIDTH       = 16,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int RAMP_LOG2       = 8,
  parameter int FLUSH_SAMPLES   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [SEL_WIDTH-1:0]  sw_i,
  output logic [SEL_WIDTH-1:0]  sel_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  vld_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  vld_o,
  output logic                  busy_o
);

  localparam int SYNC_W = SEL_WIDTH + 1;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GAIN_W = RAMP_LOG2 + 1;
  localparam int FL_W   = $clog2(FLUSH_SAMPLES + 1);
  localparam int PROD_W = DATA_WIDTH + RAMP_LOG2 + 2;
  localparam logic [GAIN_W-1:0] GAIN_UNITY = {1'b1, {RAMP_LOG2{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAMP_DN,
    S_SWAP,
    S_FLUSH,
    S_RAMP_UP
  } state_t;

  logic [SYNC_W-1:0]     r_sync1, r_sync2, r_stable;
  logic [DB_W-1:0]       r_db_cnt;
  state_t                r_state, w_state_next;
  logic [GAIN_W-1:0]     r_gain, w_gain_next;
  logic [FL_W-1:0]       r_flush_cnt, w_flush_next;
  logic [SEL_WIDTH-1:0]  r_tgt, w_tgt_next;
  logic [SEL_WIDTH-1:0]  r_sel, w_sel_next;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_vld, r_busy;
  logic [SEL_WIDTH-1:0]  w_target;
  logic                  w_req;
  logic signed [PROD_W-1:0] w_product;

  // Two-flop synchroniser for the enable bit and the switch word together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {en_i, sw_i};
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: accept the synced word once it has differed from the stable word, unchanged,
  // for DEBOUNCE_CYCLES cycles; any movement of the synced word restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stable <= '0;
      r_db_cnt <= '0;
    end else if ((r_sync1 != r_sync2) || (r_sync2 == r_stable)) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      r_stable <= r_sync2;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  assign w_target = r_stable[SEL_WIDTH] ? r_stable[SEL_WIDTH-1:0] : '0;
  assign w_req    = (w_target != r_sel);

  // Sequencer state and its counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_gain      <= GAIN_UNITY;
      r_flush_cnt <= '0;
      r_tgt       <= '0;
      r_sel       <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_gain      <= w_gain_next;
      r_flush_cnt <= w_flush_next;
      r_tgt       <= w_tgt_next;
      r_sel       <= w_sel_next;
      r_busy      <= (r_state != S_IDLE);
    end
  end

  // Next-state logic; gain and flush counter only move on valid samples
  always_comb begin
    w_state_next = r_state;
    w_gain_next  = r_gain;
    w_flush_next = r_flush_cnt;
    w_tgt_next   = r_tgt;
    w_sel_next   = r_sel;
    case (r_state)
      S_IDLE: begin
        w_gain_next = GAIN_UNITY;
        if (w_req) begin
          w_tgt_next   = w_target;
          w_state_next = S_RAMP_DN;
        end
      end
      S_RAMP_DN: begin
        if (vld_i) begin
          w_gain_next = r_gain - GAIN_W'(1);
          if (r_gain == GAIN_W'(1)) w_state_next = S_SWAP;
        end
      end
      S_SWAP: begin
        w_sel_next   = r_tgt;
        w_flush_next = FL_W'(FLUSH_SAMPLES);
        w_state_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (vld_i) begin
          w_flush_next = r_flush_cnt - FL_W'(1);
          if (r_flush_cnt == FL_W'(1)) w_state_next = S_RAMP_UP;
        end
      end
      S_RAMP_UP: begin
        if (vld_i) begin
          w_gain_next = r_gain + GAIN_W'(1);
          if (r_gain == GAIN_UNITY - GAIN_W'(1)) w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Signed sample times unsigned gain; the shift floors toward -inf and unity is exact
  assign w_product = PROD_W'($signed(data_i)) * PROD_W'($signed({1'b0, r_gain}));

  // One-cycle registered datapath; output holds between valid samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= vld_i;
      if (vld_i) r_data <= DATA_WIDTH'(w_product >>> RAMP_LOG2);
    end
  end

  assign sel_o  = r_sel;
  assign data_o = r_data;
  assign vld_o  = r_vld;
  assign busy_o = r_busy;

endmodule

// File: tb/tb_eff_sel_ctrl.sv
// Directed bench for eff_sel_ctrl with short debounce/ramp/flush settings.
module tb_eff_sel_ctrl;
  localparam int DW = 24;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst, en_i, vld_i;
  logic [SW-1:0] sw_i, sel_o;
  logic [DW-1:0] data_i, data_o;
  logic          vld_o, busy_o;

  always #5 clk = ~clk;

  eff_sel_ctrl #(
    .DATA_WIDTH(DW), .SEL_WIDTH(SW), .DEBOUNCE_CYCLES(1000),
    .RAMP_LOG2(2), .FLUSH_SAMPLES(3)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .sw_i(sw_i), .sel_o(sel_o),
    .data_i(data_i), .vld_i(vld_i), .data_o(data_o), .vld_o(vld_o), .busy_o(busy_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] s_out;
  logic          s_vld, s_busy_b, s_busy_c, s_busy_d;
  logic [SW-1:0] s_sel_b, s_sel_d;

  logic [DW-1:0] rec_out   [0:279];
  logic [SW-1:0] rec_sel_b [0:279];
  logic [SW-1:0] rec_sel_d [0:279];
  logic [DW-1:0] pat [0:11] = '{24'h100000, 24'h0C0000, 24'h080000, 24'h040000,
                                24'h000000, 24'h000000, 24'h000000, 24'h000000,
                                24'h040000, 24'h080000, 24'h0C0000, 24'h100000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      $display("[TB] ok   %s obs=%h exp=%h", tag, obs, exp);
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One sample slot of 4 clocks: vld_i high for the first clock
  task automatic sample(input logic [DW-1:0] d);
    @(negedge clk);
    data_i = d;
    vld_i  = 1'b1;
    @(negedge clk);
    vld_i    = 1'b0;
    s_out    = data_o;
    s_vld    = vld_o;
    s_sel_b  = sel_o;
    s_busy_b = busy_o;
    @(negedge clk);
    s_busy_c = busy_o;
    @(negedge clk);
    s_busy_d = busy_o;
    s_sel_d  = sel_o;
  endtask

  task automatic wait_sel(input logic [SW-1:0] v, input string tag);
    for (int j = 0; j < 400; j++) begin
      sample(24'h100000);
      if (s_sel_d == v && s_busy_d == 1'b0) break;
    end
    check({tag, "_sel"}, 32'(sel_o), 32'(v));
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  task automatic wait_out(input logic [DW-1:0] v, input logic [DW-1:0] d, input string tag);
    logic found;
    found = 1'b0;
    for (int j = 0; j < 300 && !found; j++) begin
      sample(d);
      if (s_out == v) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  st;
    logic saw_bad, found;

    rst = 1'b1; en_i = 1'b0; sw_i = '0; data_i = '0; vld_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sel", 32'(sel_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_vld", 32'(vld_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    rst = 1'b0;
    sample(24'h100000);
    check("unity_pass", 32'(s_out), 32'h100000);
    check("unity_vld", 32'(s_vld), 32'd1);

    // Bouncing switch: nothing may be accepted
    en_i = 1'b1;
    saw_bad = 1'b0;
    for (int t = 0; t < 50; t++) begin
      sw_i = (t % 2 == 0) ? 16'h0002 : 16'h0000;
      repeat (25) begin
        sample(24'h100000);
        if (busy_o || sel_o != '0) saw_bad = 1'b1;
      end
    end
    check("bounce_quiet", 32'(saw_bad), 32'd0);
    check("bounce_sel", 32'(sel_o), 32'd0);

    // Hold 0x0002 and record the full sequence
    sw_i = 16'h0002;
    for (int j = 0; j < 280; j++) begin
      sample(24'h100000);
      rec_out[j]   = s_out;
      rec_sel_b[j] = s_sel_b;
      rec_sel_d[j] = s_sel_d;
    end
    st = -1;
    for (int j = 1; j < 280; j++)
      if (st < 0 && rec_out[j] == 24'h0C0000) st = j - 1;
    found = (st >= 249 && st <= 253);
    check("seq_start_time", 32'(found), 32'd1);
    if (st < 0 || st > 260) st = 0;
    for (int k = 0; k < 12; k++)
      check($sformatf("seq_data_%0d", k), 32'(rec_out[st + k]), 32'(pat[k]));
    check("swap_before", 32'(rec_sel_d[st + 2]), 32'd0);
    check("swap_not_early", 32'(rec_sel_b[st + 3]), 32'd0);
    check("swap_after", 32'(rec_sel_d[st + 3]), 32'h0002);
    check("seq_final_busy", 32'(busy_o), 32'd0);

    // Change debounced while the previous sequence sits in RAMP_UP
    sw_i = 16'h0001;
    found = 1'b0;
    for (int j = 0; j < 400 && !found; j++) begin
      sample(24'h100000);
      if (s_sel_d == 16'h0001) found = 1'b1;
    end
    check("mid_swap_seen", 32'(found), 32'd1);
    check("mid_last_dn", 32'(s_out), 32'h040000);
    for (int k = 0; k < 4; k++) begin
      sample(24'h100000);
      check($sformatf("mid_zero_%0d", k), 32'(s_out), 32'd0);
    end
    sw_i = 16'h0002;
    repeat (1100) @(negedge clk);
    check("mid_stalled_busy", 32'(busy_o), 32'd1);
    check("mid_stalled_sel", 32'(sel_o), 32'h0001);
    sample(24'h100000);
    check("mid_up1", 32'(s_out), 32'h040000);
    sample(24'h100000);
    check("mid_up2", 32'(s_out), 32'h080000);
    sample(24'h100000);
    check("mid_up3", 32'(s_out), 32'h0C0000);
    check("mid_sel_first", 32'(s_sel_d), 32'h0001);
    check("mid_busy_b", 32'(s_busy_b), 32'd1);
    check("mid_idle_gap", 32'(s_busy_c), 32'd0);
    check("mid_busy_again", 32'(s_busy_d), 32'd1);
    sample(24'h100000);
    check("mid_re_dn4", 32'(s_out), 32'h100000);
    sample(24'h100000);
    check("mid_re_dn3", 32'(s_out), 32'h0C0000);
    wait_sel(16'h0002, "mid_done");

    // Arithmetic and master enable
    sw_i = 16'h0005;
    wait_sel(16'h0005, "to5");
    sample(24'h800000);
    check("ar_neg_unity", 32'(s_out), 32'h800000);
    sample(24'h7FFFFF);
    check("ar_pos_unity", 32'(s_out), 32'h7FFFFF);
    en_i = 1'b0;
    wait_out(24'hA00000, 24'h800000, "en_off_ramp");
    sample(24'h800000);
    check("ar_neg_half", 32'(s_out), 32'hC00000);
    sample(24'h800000);
    check("ar_neg_quarter", 32'(s_out), 32'hE00000);
    check("en_off_sel_pre", 32'(s_sel_b), 32'h0005);
    check("en_off_sel_post", 32'(s_sel_d), 32'd0);
    for (int k = 0; k < 4; k++) begin
      sample(24'h7FFFFF);
      check($sformatf("en_off_zero_%0d", k), 32'(s_out), 32'd0);
    end
    sample(24'h000003);
    check("ar_small_quarter", 32'(s_out), 32'd0);
    sample(24'hFFFFFD);
    check("ar_m3_half", 32'(s_out), 32'hFFFFFE);
    sample(24'h000004);
    check("ar_4_3q", 32'(s_out), 32'h000003);
    check("en_off_busy", 32'(s_busy_d), 32'd0);
    check("en_off_sel", 32'(sel_o), 32'd0);
    en_i = 1'b1;
    wait_out(24'h0C0000, 24'h100000, "en_on_ramp");
    sample(24'h100000);
    check("en_on_dn2", 32'(s_out), 32'h080000);
    sample(24'h100000);
    check("en_on_dn1", 32'(s_out), 32'h040000);
    check("en_on_sel", 32'(s_sel_d), 32'h0005);
    repeat (4) sample(24'h100000);
    sample(24'hFFFFFD);
    check("ar_m3_quarter", 32'(s_out), 32'hFFFFFF);
    sample(24'h100000);
    sample(24'h100000);
    sample(24'h100000);
    check("en_on_unity", 32'(s_out), 32'h100000);
    check("en_on_busy", 32'(busy_o), 32'd0);

    // Asynchronous reset in the middle of a sequence
    en_i = 1'b0;
    wait_out(24'h0C0000, 24'h100000, "rst_mid_ramp");
    @(negedge clk);
    data_i = 24'h100000;
    vld_i  = 1'b1;
    @(negedge clk);
    vld_i = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("arst_sel", 32'(sel_o), 32'd0);
    check("arst_vld", 32'(vld_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_data", 32'(data_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sample(24'h100000);
    check("post_rst_pass", 32'(s_out), 32'h100000);
    check("post_rst_vld", 32'(s_vld), 32'd1);
    check("post_rst_busy", 32'(s_busy_d), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
